// File: rtl/tracker_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tracker_audio_pkg
//  Description : Shared definitions for the tracker audio path. Holds default
//                channel and sample geometry, the mixer state encoding and
//                the 22-bit to 16-bit saturating clamp. Later effect stages
//                reuse the clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package tracker_audio_pkg;

    // Default geometry of the mixer
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_VOL_W    = 4;

    // The accumulator holds at most 4 * 32768 * 15 = 1,966,080 in magnitude,
    // so 22 signed bits never wrap
    localparam int ACC_W     = 22;

    // Attenuation applied to the accumulated sum before clamping (divide by 16)
    localparam int OUT_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } mix_state_t;

    // Clamp a 22-bit signed value into the signed 16-bit range
    function automatic logic signed [15:0] sat16(input logic signed [21:0] x);
        if (x > 22'sd32767) begin
            return 16'sh7fff;
        end else if (x < -22'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/channel_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : channel_mixer
//  Description : Time-multiplexed mixer. On each sample strobe it snapshots
//                one signed sample per channel. It then scales each sample by
//                its volume (zero when muted), one channel per cycle, and
//                attenuates the sum by 16. The result is clamped to the
//                signed 16-bit range and presented with a one-cycle valid
//                pulse. Sticky clip/overrun flags report saturation and
//                strobes that arrive while a mix is running.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk            in   system clock
//    rst_active_low in   asynchronous active-low reset
//    sample_tick    in   one-cycle sample strobe (synchronous to clk)
//    ch_sample      in   NUM_CH x SAMPLE_W signed samples, ch0 in LSBs
//    ch_volume      in   NUM_CH x VOL_W unsigned volumes, ch0 in LSBs
//    ch_mute        in   per-channel mute, 1 = silent
//    clear_flags    in   synchronous clear of clip/overrun (set wins)
//    pcm_out        out  mixed signed sample, held between updates
//    pcm_valid      out  one-cycle pulse when pcm_out updates
//    busy           out  high while a mix is in progress
//    clip           out  sticky: an output was saturated
//    overrun        out  sticky: a strobe arrived while busy
// ============================================================================
module channel_mixer
    import tracker_audio_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int VOL_W    = DEF_VOL_W
) (
    input  logic                         clk,
    input  logic                         rst_active_low,
    input  logic                         sample_tick,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_sample,
    input  logic [NUM_CH*VOL_W-1:0]      ch_volume,
    input  logic [NUM_CH-1:0]            ch_mute,
    input  logic                         clear_flags,
    output logic [SAMPLE_W-1:0]          pcm_out,
    output logic                         pcm_valid,
    output logic                         busy,
    output logic                         clip,
    output logic                         overrun
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Signed sample times zero-extended (VOL_W+1)-bit volume
    localparam int PROD_W = SAMPLE_W + VOL_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // State and snapshot registers
    // ------------------------------------------------------------------
    mix_state_t                          r_state;
    mix_state_t                          w_state_nxt;
    logic [IDX_W-1:0]                    r_idx;
    logic signed [ACC_W-1:0]             r_acc;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]     r_samp;
    logic [NUM_CH-1:0][VOL_W-1:0]        r_vol;
    logic [NUM_CH-1:0]                   r_mute;
    logic [SAMPLE_W-1:0]                 r_pcm;
    logic                                r_valid;
    logic                                r_clip;
    logic                                r_overrun;

    // ------------------------------------------------------------------
    // Datapath: current channel product and output clamp
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0]                 w_cur_samp;
    logic [VOL_W-1:0]                    w_cur_vol;
    logic signed [PROD_W-1:0]            w_samp_ext;
    logic signed [PROD_W-1:0]            w_vol_ext;
    logic signed [PROD_W-1:0]            w_prod;
    logic signed [ACC_W-1:0]             w_prod_ext;
    logic signed [ACC_W-1:0]             w_scaled;
    logic signed [15:0]                  w_sat;
    logic                                w_clipped;
    logic                                w_busy;

    assign w_cur_samp = r_samp[r_idx];
    assign w_cur_vol  = r_mute[r_idx] ? '0 : r_vol[r_idx];

    // Both operands widened to the product width so the multiply is a
    // plain signed multiply; the volume is zero-extended (always positive)
    assign w_samp_ext = {{(VOL_W + 1){w_cur_samp[SAMPLE_W-1]}}, w_cur_samp};
    assign w_vol_ext  = {{SAMPLE_W{1'b0}}, 1'b0, w_cur_vol};
    assign w_prod     = w_samp_ext * w_vol_ext;
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // Arithmetic shift floors toward negative infinity
    assign w_scaled  = r_acc >>> OUT_SHIFT;
    assign w_sat     = sat16(w_scaled);
    assign w_clipped = (w_scaled != {{(ACC_W - 16){w_sat[15]}}, w_sat});

    assign w_busy = (r_state != IDLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (sample_tick)        w_state_nxt = ACCUM;
            ACCUM:   if (r_idx == LAST_IDX)  w_state_nxt = EMIT;
            EMIT:                            w_state_nxt = IDLE;
            default:                         w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register, datapath and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            r_samp    <= '0;
            r_vol     <= '0;
            r_mute    <= '0;
            r_pcm     <= '0;
            r_valid   <= 1'b0;
            r_clip    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    // Snapshot so inputs may change freely during the mix
                    if (sample_tick) begin
                        r_samp <= ch_sample;
                        r_vol  <= ch_volume;
                        r_mute <= ch_mute;
                        r_acc  <= '0;
                        r_idx  <= '0;
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                EMIT: begin
                    r_pcm   <= SAMPLE_W'(w_sat);
                    r_valid <= 1'b1;
                end
                default: ;
            endcase

            // Sticky flags: a set event in the same cycle beats a clear
            if ((r_state == EMIT) && w_clipped) begin
                r_clip <= 1'b1;
            end else if (clear_flags) begin
                r_clip <= 1'b0;
            end

            if (sample_tick && w_busy) begin
                r_overrun <= 1'b1;
            end else if (clear_flags) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign pcm_out   = r_pcm;
    assign pcm_valid = r_valid;
    assign busy      = w_busy;
    assign clip      = r_clip;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
